// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared state encoding, line values and frame-limit helper for the keypad emulator
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNCE = 2'd1,
        HOLD   = 2'd2,
        GAP    = 2'd3
    } kp_state_e;

    localparam logic [3:0] COL_IDLE      = 4'b1111;
    localparam logic [3:0] ROW0_MARK     = 4'b1110;
    localparam int         FRAME_CNT_MAX = 255;

    // Folds a frame-count parameter into the range the 8-bit frame counter can reach.
    function automatic int clamp_frames(input int frames, input int floor_val);
        if (frames < floor_val) begin
            return floor_val;
        end
        if (frames > FRAME_CNT_MAX) begin
            return FRAME_CNT_MAX;
        end
        return frames;
    endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// rtl/keypad_emulator_if.sv - key request handshake and scanner row/column lines of the keypad emulator
interface keypad_emulator_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic [3:0] H;
    logic [3:0] V;
    logic       busy;
    logic       done;

    modport master (
        output key_valid, key_code, H,
        input  key_ready, V, busy, done
    );

    modport slave (
        input  key_valid, key_code, H,
        output key_ready, V, busy, done
    );
endinterface

// File: rtl/scan_frame_detect.sv
// rtl/scan_frame_detect.sv - registers the scanner row drive and flags the start of each scan frame
module scan_frame_detect
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] H,
    output logic       frame
);

    logic [3:0] h_q;
    logic [3:0] h_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q      <= COL_IDLE;
            h_prev_q <= COL_IDLE;
        end else begin
            h_q      <= H;
            h_prev_q <= h_q;
        end
    end

    // A frame begins when row 0 becomes selected; holding row 0 or all-high never re-triggers.
    assign frame = (h_q == ROW0_MARK) && (h_prev_q != ROW0_MARK);

endmodule

// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - emulates one matrix-keypad press (bounce, hold, release gap) against a row scanner
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_FRAMES   = 4,
    parameter int GAP_FRAMES    = 2,
    parameter int BOUNCE_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    keypad_emulator_if.slave kp
);

    localparam logic [8:0] HOLD_LIM = 9'(clamp_frames(HOLD_FRAMES, 1));
    localparam logic [8:0] GAP_LIM  = 9'(clamp_frames(GAP_FRAMES, 0));
    localparam int         BW       = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
    localparam logic [BW-1:0] BOUNCE_LAST = BW'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);

    kp_state_e     state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [3:0]    key_q, key_d;

    logic          frame;
    logic [7:0]    cnt_nxt;
    logic          lim_hit_hold;
    logic          lim_hit_gap;
    logic          done_c;
    logic          contact;
    logic [1:0]    row;
    logic [1:0]    col;
    logic [3:0]    v_c;

    scan_frame_detect u_frame (
        .clk   (clk),
        .rst_n (rst_n),
        .H     (kp.H),
        .frame (frame)
    );

    assign cnt_nxt = (frame && (cnt_q != 8'hFF)) ? cnt_q + 8'd1 : cnt_q;

    // Written as cnt+1 > LIM so a zero gap limit is simply always reached.
    assign lim_hit_hold = ({1'b0, cnt_nxt} + 9'd1) > HOLD_LIM;
    assign lim_hit_gap  = ({1'b0, cnt_nxt} + 9'd1) > GAP_LIM;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            key_q   <= key_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bcnt_d  = bcnt_q;
        key_d   = key_q;
        done_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (kp.key_valid) begin
                    key_d   = kp.key_code;
                    state_d = (BOUNCE_CYCLES > 0) ? BOUNCE : HOLD;
                end
            end
            BOUNCE: begin
                bcnt_d = bcnt_q + BW'(1);
                if (bcnt_q == BOUNCE_LAST) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                cnt_d = cnt_nxt;
                if (lim_hit_hold) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                cnt_d = cnt_nxt;
                if (lim_hit_gap) begin
                    state_d = IDLE;
                    done_c  = 1'b1;
                end
            end
        endcase
        // Both counters restart on every state entry.
        if (state_d != state_q) begin
            cnt_d  = '0;
            bcnt_d = '0;
        end
    end

    // Chatter starts closed and alternates each cycle.
    assign contact = (state_q == HOLD) || ((state_q == BOUNCE) && !bcnt_q[0]);
    assign row     = key_q[3:2];
    assign col     = key_q[1:0];

    always_comb begin
        v_c = COL_IDLE;
        if (contact && !kp.H[row]) begin
            v_c[col] = 1'b0;
        end
    end

    assign kp.V         = v_c;
    assign kp.key_ready = (state_q == IDLE);
    assign kp.busy      = (state_q != IDLE);
    assign kp.done      = done_c;

endmodule

// File: doc/keypad_emulator.md
KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 Parameter HOLD_FRAMES, default 4: number of complete scan frames a key stays closed; 0 is treated as 1.
REQ-002 Parameter GAP_FRAMES, default 2: number of scan frames the key stays open after release before the next key is accepted; 0 is legal.
REQ-003 Parameter BOUNCE_CYCLES, default 0: number of clk cycles of contact chatter at press start.
REQ-004 clk  input  1  system clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  asynchronous reset, active-low.
REQ-006 key_valid  input  1  key request present.
REQ-007 key_code  input  4  key index: row = key_code[3:2], column = key_code[1:0].
REQ-008 key_ready  output  1  emulator can accept a request.
REQ-009 H  input  4  row drive from the scanner; exactly one bit low selects a row.
REQ-010 V  output  4  column return to the scanner; idle value 4'b1111.
REQ-011 busy  output  1  a press/release sequence is in progress.
REQ-012 done  output  1  one-cycle pulse when a sequence completes.

Function
REQ-013 The state machine SHALL have four states: IDLE, BOUNCE, HOLD and GAP.
REQ-014 key_ready SHALL be 1 only in IDLE; key_code SHALL be latched on the edge where key_valid and key_ready are both 1.
REQ-015 On acceptance the state SHALL go to BOUNCE if BOUNCE_CYCLES>0, otherwise to HOLD.
REQ-016 In BOUNCE the contact SHALL toggle every clk, starting closed, for BOUNCE_CYCLES cycles; the state SHALL then go to HOLD.
REQ-017 In HOLD the contact SHALL be closed continuously.
REQ-018 In HOLD the state SHALL go to GAP after HOLD_FRAMES frame events counted from HOLD entry.
REQ-019 A frame event SHALL be a cycle where the registered H equals 4'b1110 and the previous registered H did not.
REQ-020 Any H value other than 4'b1110 SHALL NOT count as a frame event, including 4'b1111.
REQ-021 In GAP the contact SHALL be open.
REQ-022 In GAP the state SHALL go to IDLE after GAP_FRAMES frame events; with GAP_FRAMES=0 it SHALL go to IDLE on the cycle after GAP entry.
REQ-023 done SHALL pulse for exactly one cycle on the GAP->IDLE transition.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 V SHALL be combinational from H and registered state, with zero latency to H.
REQ-026 When the contact is closed and H[row]=0, V SHALL equal 4'b1111 with bit [column] cleared; otherwise V SHALL be 4'b1111.
REQ-027 If several H bits are low, V SHALL respond whenever H[row]=0.
REQ-028 The frame counter SHALL be 8 bits, saturate at 255, and clear on every state entry.
REQ-029 HOLD_FRAMES and GAP_FRAMES SHALL be limited to 1..255 and 0..255 respectively.
REQ-030 key_valid asserted while busy SHALL be ignored and SHALL NOT be latched.

Reset
REQ-031 On rst_n=0, asynchronously: state=IDLE, V=4'b1111, key_ready=1, busy=0, done=0, counters=0, latched key=0, H history=4'b1111.
REQ-032 Reset asserted mid-sequence SHALL abort the sequence immediately, with V=4'b1111 and no done pulse.

Structure
REQ-033 The state encoding, the idle column value 4'b1111 and the row-0 frame marker 4'b1110 SHALL live in a shared package, keypad_pkg.
REQ-034 Frame-event detection SHALL be one sub-module, scan_frame_detect (inputs H, clk, rst_n; output frame pulse); all other logic stays flat.

Verification
REQ-035 Scanner rotates H 1110->1101->1011->0111; key_code=4'b0110 accepted -> V=4'b1011 only while H=4'b1101, for 4 frames, then 4'b1111; done after 2 more frames.
REQ-036 key_valid held high across a whole sequence -> second acceptance only in the cycle after done; key_ready=0 throughout.
REQ-037 BOUNCE_CYCLES=5, key_code=0, H held at 4'b1110 -> V[0] toggles 0,1,0,1,0 then stays 0.
REQ-038 H held at 4'b1111 during HOLD -> V=4'b1111, no frame events, state stays HOLD indefinitely.
REQ-039 rst_n pulsed low during HOLD -> V=4'b1111 in the same cycle; key_ready=1 after release; done never pulses.
REQ-040 GAP_FRAMES=0, HOLD_FRAMES=0 -> contact closed for exactly 1 frame; done 1 cycle after GAP entry.
